// File: rtl/avalon_pio_master.sv
// Avalon-MM initiator issuing single-beat PIO reads/writes from a command/response handshake.
// Optional waitrequest timeout is built when AVALON_PIO_MASTER_TIMEOUT_EN is defined.
module avalon_pio_master #(
    parameter int ADDR_W         = 2,
    parameter int READ_LATENCY   = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic              avm_read_n,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, RESP} state_t;

    localparam logic [2:0] LAT_INIT = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;

    state_t              state_q, state_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                cs_q, cs_d;
    logic                wr_n_q, wr_n_d;
    logic                rd_n_q, rd_n_d;
    logic                ready_q, ready_d;
    logic                rvalid_q, rvalid_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [2:0]          lat_q, lat_d;
`ifdef AVALON_PIO_MASTER_TIMEOUT_EN
    logic [15:0]         to_q, to_d;
    logic                err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cs_d     = cs_q;
        wr_n_d   = wr_n_q;
        rd_n_d   = rd_n_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        lat_d    = lat_q;
`ifdef AVALON_PIO_MASTER_TIMEOUT_EN
        to_d     = to_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid && ready_q) begin
                    state_d = ACCESS;
                    write_d = cmd_write;
                    addr_d  = cmd_address;
                    wdata_d = cmd_wdata;
                    cs_d    = 1'b1;
                    wr_n_d  = ~cmd_write;
                    rd_n_d  = cmd_write;
`ifdef AVALON_PIO_MASTER_TIMEOUT_EN
                    to_d    = 16'd0;
`endif
                end
            end
            ACCESS: begin
                if (!avm_waitrequest) begin
                    cs_d   = 1'b0;
                    wr_n_d = 1'b1;
                    rd_n_d = 1'b1;
                    if (write_q || READ_LATENCY == 0) begin
                        state_d  = RESP;
                        rvalid_d = 1'b1;
                        rdata_d  = write_q ? 32'd0 : avm_readdata;
`ifdef AVALON_PIO_MASTER_TIMEOUT_EN
                        err_d    = 1'b0;
`endif
                    end else begin
                        state_d = RDWAIT;
                        lat_d   = LAT_INIT;
                    end
                end
`ifdef AVALON_PIO_MASTER_TIMEOUT_EN
                else begin
                    // Abort in the stalled cycle that brings the count up to the limit.
                    to_d = to_q + 16'd1;
                    if (to_d == 16'(TIMEOUT_CYCLES)) begin
                        cs_d     = 1'b0;
                        wr_n_d   = 1'b1;
                        rd_n_d   = 1'b1;
                        state_d  = RESP;
                        rvalid_d = 1'b1;
                        rdata_d  = 32'd0;
                        err_d    = 1'b1;
                    end
                end
`endif
            end
            RDWAIT: begin
                if (lat_q == 3'd0) begin
                    state_d  = RESP;
                    rvalid_d = 1'b1;
                    rdata_d  = avm_readdata;
`ifdef AVALON_PIO_MASTER_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            cs_q     <= 1'b0;
            wr_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            lat_q    <= 3'd0;
`ifdef AVALON_PIO_MASTER_TIMEOUT_EN
            to_q     <= 16'd0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cs_q     <= cs_d;
            wr_n_q   <= wr_n_d;
            rd_n_q   <= rd_n_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            lat_q    <= lat_d;
`ifdef AVALON_PIO_MASTER_TIMEOUT_EN
            to_q     <= to_d;
            err_q    <= err_d;
`endif
        end
    end

    assign cmd_ready      = ready_q;
    assign rsp_valid      = rvalid_q;
    assign rsp_rdata      = rdata_q;
    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = wr_n_q;
    assign avm_read_n     = rd_n_q;
    assign avm_writedata  = wdata_q;
`ifdef AVALON_PIO_MASTER_TIMEOUT_EN
    assign rsp_error      = err_q;
`else
    assign rsp_error      = 1'b0;
`endif

endmodule

// File: tb/tb_avalon_pio_master.sv
// Directed bench: instance A is a zero-latency PIO master with a modelled PIO slave,
// instance B uses READ_LATENCY=2 and TIMEOUT_CYCLES=8 for stall, timeout and reset cases.
module tb_avalon_pio_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic        aCmdValid, aCmdReady, aCmdWrite;
    logic [1:0]  aCmdAddress;
    logic [31:0] aCmdWdata;
    logic        aRspValid, aRspError;
    logic [31:0] aRspRdata;
    logic [1:0]  aAvmAddress;
    logic        aCs, aWrN, aRdN;
    logic [31:0] aAvmWdata, aAvmRdata;
    logic        aWait;

    logic        bCmdValid, bCmdReady, bCmdWrite;
    logic [1:0]  bCmdAddress;
    logic [31:0] bCmdWdata;
    logic        bRspValid, bRspError;
    logic [31:0] bRspRdata;
    logic [1:0]  bAvmAddress;
    logic        bCs, bWrN, bRdN;
    logic [31:0] bAvmWdata, bAvmRdata;
    logic        bWait;

    logic [31:0] outPort = 32'd0;

    avalon_pio_master #(.ADDR_W(2), .READ_LATENCY(0), .TIMEOUT_CYCLES(8)) dutA (
        .clk(clk), .reset(reset),
        .cmd_valid(aCmdValid), .cmd_ready(aCmdReady), .cmd_write(aCmdWrite),
        .cmd_address(aCmdAddress), .cmd_wdata(aCmdWdata),
        .rsp_valid(aRspValid), .rsp_rdata(aRspRdata), .rsp_error(aRspError),
        .avm_address(aAvmAddress), .avm_chipselect(aCs), .avm_write_n(aWrN),
        .avm_read_n(aRdN), .avm_writedata(aAvmWdata), .avm_readdata(aAvmRdata),
        .avm_waitrequest(aWait)
    );

    avalon_pio_master #(.ADDR_W(2), .READ_LATENCY(2), .TIMEOUT_CYCLES(8)) dutB (
        .clk(clk), .reset(reset),
        .cmd_valid(bCmdValid), .cmd_ready(bCmdReady), .cmd_write(bCmdWrite),
        .cmd_address(bCmdAddress), .cmd_wdata(bCmdWdata),
        .rsp_valid(bRspValid), .rsp_rdata(bRspRdata), .rsp_error(bRspError),
        .avm_address(bAvmAddress), .avm_chipselect(bCs), .avm_write_n(bWrN),
        .avm_read_n(bRdN), .avm_writedata(bAvmWdata), .avm_readdata(bAvmRdata),
        .avm_waitrequest(bWait)
    );

    // PIO slave model: output register at word 0, input port reading 0x3C at word 0
    always @(posedge clk) begin
        if (aCs && !aWrN && aAvmAddress == 2'd0) outPort <= aAvmWdata;
    end
    assign aAvmRdata = (aAvmAddress == 2'd0) ? 32'h0000_003C : 32'h0;
    assign aWait     = 1'b0;

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (aCs !== 1'b0 || aWrN !== 1'b1 || aRdN !== 1'b1) begin bad++; $display("[TB] FAIL rst_strobes cs=%b wr_n=%b rd_n=%b exp 0/1/1", aCs, aWrN, aRdN); end
        total++; if (aRspValid !== 1'b0 || aRspRdata !== 32'd0 || aRspError !== 1'b0) begin bad++; $display("[TB] FAIL rst_rsp valid=%b rdata=%h err=%b exp 0/0/0", aRspValid, aRspRdata, aRspError); end
        total++; if (aCmdReady !== 1'b0 || bCmdReady !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready a=%b b=%b exp 0", aCmdReady, bCmdReady); end
        total++; if (aAvmAddress !== 2'd0 || aAvmWdata !== 32'd0) begin bad++; $display("[TB] FAIL rst_bus addr=%h wdata=%h exp 0", aAvmAddress, aAvmWdata); end
        reset = 1'b0;
        @(negedge clk);
        total++; if (aCmdReady !== 1'b1 || bCmdReady !== 1'b1) begin bad++; $display("[TB] FAIL rst_release_ready a=%b b=%b exp 1", aCmdReady, bCmdReady); end
    endtask

    task automatic test_write();
        aCmdValid = 1'b1; aCmdWrite = 1'b1; aCmdAddress = 2'd0; aCmdWdata = 32'h0000_00A5;
        @(negedge clk);
        aCmdValid = 1'b0;
        total++; if (aCs !== 1'b1 || aWrN !== 1'b0 || aRdN !== 1'b1) begin bad++; $display("[TB] FAIL wr_strobe cs=%b wr_n=%b rd_n=%b exp 1/0/1", aCs, aWrN, aRdN); end
        total++; if (aAvmWdata !== 32'h0000_00A5 || aAvmAddress !== 2'd0) begin bad++; $display("[TB] FAIL wr_bus wdata=%h addr=%h exp a5/0", aAvmWdata, aAvmAddress); end
        total++; if (aCmdReady !== 1'b0 || aRspValid !== 1'b0) begin bad++; $display("[TB] FAIL wr_busy ready=%b rsp=%b exp 0/0", aCmdReady, aRspValid); end
        @(negedge clk);
        total++; if (aRspValid !== 1'b1 || aRspRdata !== 32'd0 || aRspError !== 1'b0) begin bad++; $display("[TB] FAIL wr_rsp valid=%b rdata=%h err=%b exp 1/0/0", aRspValid, aRspRdata, aRspError); end
        total++; if (aCs !== 1'b0 || aWrN !== 1'b1) begin bad++; $display("[TB] FAIL wr_release cs=%b wr_n=%b exp 0/1", aCs, aWrN); end
        @(negedge clk);
        total++; if (aRspValid !== 1'b0 || aCmdReady !== 1'b1) begin bad++; $display("[TB] FAIL wr_idle rsp=%b ready=%b exp 0/1", aRspValid, aCmdReady); end
        total++; if (outPort !== 32'h0000_00A5) begin bad++; $display("[TB] FAIL wr_out_port got=%h exp a5", outPort); end
    endtask

    task automatic test_read(input logic [1:0] addr, input logic [31:0] expData);
        aCmdValid = 1'b1; aCmdWrite = 1'b0; aCmdAddress = addr; aCmdWdata = 32'hFFFF_FFFF;
        @(negedge clk);
        aCmdValid = 1'b0;
        total++; if (aCs !== 1'b1 || aRdN !== 1'b0 || aWrN !== 1'b1 || aAvmAddress !== addr) begin bad++; $display("[TB] FAIL rd_strobe cs=%b rd_n=%b wr_n=%b addr=%h exp 1/0/1/%h", aCs, aRdN, aWrN, aAvmAddress, addr); end
        @(negedge clk);
        total++; if (aRspValid !== 1'b1 || aRspRdata !== expData || aRspError !== 1'b0) begin bad++; $display("[TB] FAIL rd_rsp valid=%b rdata=%h err=%b exp 1/%h/0", aRspValid, aRspRdata, aRspError, expData); end
        @(negedge clk);
        total++; if (aRspValid !== 1'b0 || aRspRdata !== expData) begin bad++; $display("[TB] FAIL rd_hold valid=%b rdata=%h exp 0/%h", aRspValid, aRspRdata, expData); end
    endtask

    task automatic test_back_to_back();
        bit [5:0] rdyPat, csPat, rvPat;
        rdyPat = 6'b100100; csPat = 6'b001001; rvPat = 6'b010010;
        aCmdValid = 1'b1; aCmdWrite = 1'b1; aCmdAddress = 2'd1; aCmdWdata = 32'h11;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (aCmdReady !== rdyPat[i] || aCs !== csPat[i] || aRspValid !== rvPat[i] ||
                aAvmWdata !== ((i < 3) ? 32'h11 : 32'h22)) begin
                bad++;
                $display("[TB] FAIL b2b_cycle%0d ready=%b cs=%b rsp=%b wdata=%h exp %b/%b/%b/%h", i + 1,
                         aCmdReady, aCs, aRspValid, aAvmWdata, rdyPat[i], csPat[i], rvPat[i], (i < 3) ? 32'h11 : 32'h22);
            end
            if (i == 0) aCmdWdata = 32'h22;
            if (i == 3) aCmdValid = 1'b0;
        end
    endtask

    task automatic test_stall_rl2();
        bWait = 1'b1; bAvmRdata = 32'hDEAD_BEEF;
        bCmdValid = 1'b1; bCmdWrite = 1'b0; bCmdAddress = 2'd2; bCmdWdata = 32'd0;
        @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            total++;
            if (bCs !== 1'b1 || bRdN !== 1'b0 || bCmdReady !== 1'b0 || bAvmAddress !== 2'd2) begin
                bad++; $display("[TB] FAIL stall_hold%0d cs=%b rd_n=%b ready=%b addr=%h exp 1/0/0/2", i, bCs, bRdN, bCmdReady, bAvmAddress);
            end
            if (i == 1) begin bCmdWrite = 1'b1; bCmdAddress = 2'd3; bCmdWdata = 32'h0000_CAFE; end
            bWait = (i < 5);
            @(negedge clk);
        end
        total++; if (bCs !== 1'b0 || bRdN !== 1'b1 || bRspValid !== 1'b0 || bCmdReady !== 1'b0) begin bad++; $display("[TB] FAIL stall_rdwait cs=%b rd_n=%b rsp=%b ready=%b exp 0/1/0/0", bCs, bRdN, bRspValid, bCmdReady); end
        bWait = 1'b1;
        @(negedge clk);
        total++; if (bRspValid !== 1'b0) begin bad++; $display("[TB] FAIL stall_early_rsp got=%b exp 0", bRspValid); end
        bAvmRdata = 32'h1234_5678;
        @(negedge clk);
        bAvmRdata = 32'hDEAD_BEEF;
        total++; if (bRspValid !== 1'b1 || bRspRdata !== 32'h1234_5678 || bRspError !== 1'b0) begin bad++; $display("[TB] FAIL stall_rsp valid=%b rdata=%h err=%b exp 1/12345678/0", bRspValid, bRspRdata, bRspError); end
        bWait = 1'b0;
        @(negedge clk);
        total++; if (bCmdReady !== 1'b1 || bRspValid !== 1'b0 || bRspRdata !== 32'h1234_5678) begin bad++; $display("[TB] FAIL stall_idle ready=%b rsp=%b rdata=%h exp 1/0/12345678", bCmdReady, bRspValid, bRspRdata); end
        @(negedge clk);
        bCmdValid = 1'b0;
        total++; if (bCs !== 1'b1 || bWrN !== 1'b0 || bAvmWdata !== 32'h0000_CAFE || bAvmAddress !== 2'd3) begin bad++; $display("[TB] FAIL held_cmd cs=%b wr_n=%b wdata=%h addr=%h exp 1/0/cafe/3", bCs, bWrN, bAvmWdata, bAvmAddress); end
        @(negedge clk);
        total++; if (bRspValid !== 1'b1 || bRspRdata !== 32'd0) begin bad++; $display("[TB] FAIL held_rsp valid=%b rdata=%h exp 1/0", bRspValid, bRspRdata); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int  seen;
        bWait = 1'b1;
        bCmdValid = 1'b1; bCmdWrite = 1'b0; bCmdAddress = 2'd0;
        @(negedge clk);
        bCmdValid = 1'b0;
`ifdef AVALON_PIO_MASTER_TIMEOUT_EN
        seen = 0;
        for (int i = 1; i <= 8; i++) begin
            if (bCs !== 1'b1) seen++;
            @(negedge clk);
        end
        total++; if (seen != 0) begin bad++; $display("[TB] FAIL to_hold dropped_cycles=%0d exp 0", seen); end
        total++; if (bRspValid !== 1'b1 || bRspError !== 1'b1 || bRspRdata !== 32'd0 || bCs !== 1'b0) begin bad++; $display("[TB] FAIL to_rsp valid=%b err=%b rdata=%h cs=%b exp 1/1/0/0", bRspValid, bRspError, bRspRdata, bCs); end
        @(negedge clk);
        total++; if (bCmdReady !== 1'b1) begin bad++; $display("[TB] FAIL to_ready got=%b exp 1", bCmdReady); end
        bWait = 1'b0;
`else
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (bRspValid === 1'b1 || bCs !== 1'b1) seen++;
            @(negedge clk);
        end
        total++; if (seen != 0) begin bad++; $display("[TB] FAIL notimeout_wait bad_cycles=%0d exp 0", seen); end
        bWait = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge clk);
            if (bRspValid === 1'b1) seen = 1;
        end
        total++; if (seen != 1 || bRspError !== 1'b0) begin bad++; $display("[TB] FAIL notimeout_finish seen=%0d err=%b exp 1/0", seen, bRspError); end
        @(negedge clk);
`endif
    endtask

    task automatic test_reset_mid_access();
        int seen;
        bWait = 1'b1;
        bCmdValid = 1'b1; bCmdWrite = 1'b0; bCmdAddress = 2'd1;
        @(negedge clk);
        bCmdValid = 1'b0;
        @(negedge clk);
        total++; if (bCs !== 1'b1 || bRdN !== 1'b0) begin bad++; $display("[TB] FAIL mid_access cs=%b rd_n=%b exp 1/0", bCs, bRdN); end
        reset = 1'b1;
        @(negedge clk);
        total++; if (bCs !== 1'b0 || bRdN !== 1'b1 || bRspValid !== 1'b0 || bCmdReady !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset cs=%b rd_n=%b rsp=%b ready=%b exp 0/1/0/0", bCs, bRdN, bRspValid, bCmdReady); end
        reset = 1'b0; bWait = 1'b0;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bRspValid === 1'b1) seen++;
        end
        total++; if (seen != 0 || bCmdReady !== 1'b1) begin bad++; $display("[TB] FAIL mid_no_rsp pulses=%0d ready=%b exp 0/1", seen, bCmdReady); end
        bCmdValid = 1'b1; bCmdWrite = 1'b1; bCmdAddress = 2'd1; bCmdWdata = 32'h77;
        @(negedge clk);
        bCmdValid = 1'b0;
        total++; if (bCs !== 1'b1 || bWrN !== 1'b0 || bAvmWdata !== 32'h77) begin bad++; $display("[TB] FAIL mid_next_strobe cs=%b wr_n=%b wdata=%h exp 1/0/77", bCs, bWrN, bAvmWdata); end
        @(negedge clk);
        total++; if (bRspValid !== 1'b1 || bRspError !== 1'b0 || bRspRdata !== 32'd0) begin bad++; $display("[TB] FAIL mid_next_rsp valid=%b err=%b rdata=%h exp 1/0/0", bRspValid, bRspError, bRspRdata); end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        aCmdValid = 1'b0; aCmdWrite = 1'b0; aCmdAddress = 2'd0; aCmdWdata = 32'd0;
        bCmdValid = 1'b0; bCmdWrite = 1'b0; bCmdAddress = 2'd0; bCmdWdata = 32'd0;
        bWait = 1'b0; bAvmRdata = 32'hDEAD_BEEF;
        test_reset();
        test_write();
        test_read(2'd0, 32'h0000_003C);
        test_read(2'd1, 32'h0000_0000);
        test_back_to_back();
        test_stall_rl2();
        test_timeout();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
